// File: rtl/mult_dispatch.sv
// mult_dispatch: FIFO-buffered operand feeder for a start/ready sequential multiplier,
// returning each product with its operands and flagging multiplier protocol errors.
module mult_dispatch #(
  parameter int N = 8,
  parameter int DEPTH = 4
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [N-1:0]           in_a,
  input  logic [N-1:0]           in_b,
  output logic                   mul_start,
  output logic [N-1:0]           mul_multiplicand,
  output logic [N-1:0]           mul_multiplier,
  input  logic                   mul_ready,
  input  logic [2*N-1:0]         mul_product,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [N-1:0]           out_a,
  output logic [N-1:0]           out_b,
  output logic [2*N-1:0]         out_product,
  output logic [$clog2(DEPTH):0] fifo_count,
  output logic                   proto_err
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(N + 3);
  typedef enum logic [1:0] {IDLE, START, WAIT, DONE} state_t;
  state_t state, state_nx;
  logic [2*N-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] wcnt;
  logic push, pop, can_issue, timeout, finish;
  assign in_ready = fifo_count != (AW+1)'(DEPTH);
  assign push = in_valid && in_ready;
  assign can_issue = fifo_count != '0 && mul_ready;
  assign pop = can_issue && (state == IDLE || (state == DONE && out_ready));
  assign timeout = !mul_ready && wcnt == CW'(N + 1);
  assign finish = state == WAIT && (mul_ready || timeout);
  assign mul_start = state == START;
  assign out_valid = state == DONE;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = can_issue ? START : IDLE;
      START:   state_nx = WAIT;
      WAIT:    state_nx = (mul_ready || timeout) ? DONE : WAIT;
      DONE:    state_nx = !out_ready ? DONE : can_issue ? START : IDLE;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clock)
    if (push) mem[wr_ptr] <= {in_a, in_b};
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      wr_ptr <= '0;
      rd_ptr <= '0;
      fifo_count <= '0;
      wcnt <= '0;
      mul_multiplicand <= '0;
      mul_multiplier <= '0;
      out_a <= '0;
      out_b <= '0;
      out_product <= '0;
      proto_err <= 1'b0;
    end else begin
      state <= state_nx;
      wr_ptr <= push ? wr_ptr + 1'b1 : wr_ptr;
      rd_ptr <= pop ? rd_ptr + 1'b1 : rd_ptr;
      fifo_count <= fifo_count + (AW+1)'(push) - (AW+1)'(pop);
      wcnt <= state == WAIT ? wcnt + 1'b1 : '0;
      if (pop) {mul_multiplicand, mul_multiplier} <= mem[rd_ptr];
      if (finish) begin
        out_a <= mul_multiplicand;
        out_b <= mul_multiplier;
        out_product <= mul_ready ? mul_product : '0;
      end
      // ready still high right after start means the multiplier never took the job
      if (finish && (timeout || wcnt == '0)) proto_err <= 1'b1;
    end
  end
endmodule

// File: tb/tb_mult_dispatch.sv
// tb_mult_dispatch: directed checks of mult_dispatch against a behavioural multiplier.
module tb_mult_dispatch;
  localparam int N = 8;
  localparam int DEPTH = 4;
  logic clock = 1'b0;
  logic reset = 1'b1;
  logic in_valid = 1'b0, in_ready, out_ready = 1'b0;
  logic [N-1:0] in_a = '0, in_b = '0, mul_multiplicand, mul_multiplier, out_a, out_b;
  logic mul_start, mul_ready, out_valid, proto_err;
  logic [2*N-1:0] mul_product, out_product;
  logic [$clog2(DEPTH):0] fifo_count;
  int total = 0, bad = 0, cyc = 0, t0;
  logic busy, hang = 1'b0;
  int mcnt;
  logic [2*N-1:0] mprod;
  logic [2*N-1:0] q_p[$];
  logic [N-1:0] q_a[$], q_b[$];

  mult_dispatch #(.N(N), .DEPTH(DEPTH)) dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .mul_start(mul_start),
    .mul_multiplicand(mul_multiplicand), .mul_multiplier(mul_multiplier),
    .mul_ready(mul_ready), .mul_product(mul_product), .out_valid(out_valid),
    .out_ready(out_ready), .out_a(out_a), .out_b(out_b), .out_product(out_product),
    .fifo_count(fifo_count), .proto_err(proto_err)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  // multiplier: drops ready after start, result ready N edges later; hang stalls it
  assign mul_ready = !busy;
  assign mul_product = mprod;
  always @(posedge clock) begin
    if (reset) begin
      busy <= 1'b0;
      mcnt <= 0;
      mprod <= '0;
    end else if (mul_start) begin
      busy <= 1'b1;
      mcnt <= N - 1;
    end else if (busy) begin
      if (mcnt != 0) mcnt <= mcnt - 1;
      else if (!hang) begin
        busy <= 1'b0;
        mprod <= mul_multiplicand * mul_multiplier;
      end
    end
  end

  always @(negedge clock)
    if (!reset && out_valid && out_ready) begin
      q_p.push_back(out_product);
      q_a.push_back(out_a);
      q_b.push_back(out_b);
    end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic push(input logic [N-1:0] a, input logic [N-1:0] b);
    in_valid = 1'b1;
    in_a = a;
    in_b = b;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_q(input int n, input string tag);
    for (int i = 0; i < 300 && q_p.size() < n; i++) tick();
    chk(tag, q_p.size(), n);
  endtask

  task automatic wait_valid();
    for (int i = 0; i < 60 && !out_valid; i++) tick();
  endtask

  task automatic clear_q();
    q_p.delete();
    q_a.delete();
    q_b.delete();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [N-1:0] a2[4] = '{255, 0, 1, 128};
    logic [N-1:0] b2[4] = '{255, 200, 1, 2};
    logic [2*N-1:0] e2[4] = '{65025, 0, 1, 256};
    logic [N-1:0] a3[5] = '{10, 20, 7, 15, 200};
    logic [N-1:0] b3[5] = '{10, 3, 7, 17, 100};
    logic [2*N-1:0] e3[5] = '{100, 60, 49, 255, 20000};
    logic [2*N-1:0] e4[4] = '{6, 20, 42, 72};
    repeat (3) tick();
    reset = 1'b0;
    chk("rst_count", fifo_count, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_mul_start", mul_start, 0);
    chk("rst_proto_err", proto_err, 0);
    chk("rst_out_product", out_product, 0);
    chk("rst_operand", mul_multiplicand, 0);

    out_ready = 1'b1;
    push(3, 5);
    t0 = cyc;
    wait_valid();
    chk("t1_latency", cyc - t0, N + 3);
    chk("t1_product", out_product, 15);
    chk("t1_a", out_a, 3);
    chk("t1_b", out_b, 5);
    chk("t1_proto_err", proto_err, 0);
    repeat (3) tick();

    clear_q();
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("t2_in_ready%0d", i), in_ready, 1);
      push(a2[i], b2[i]);
    end
    wait_q(4, "t2_count");
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("t2_product%0d", i), q_p[i], e2[i]);
      chk($sformatf("t2_a%0d", i), q_a[i], a2[i]);
    end
    repeat (3) tick();

    clear_q();
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("t3_in_ready%0d", i), in_ready, 1);
      push(a3[i], b3[i]);
    end
    chk("t3_full_count", fifo_count, 4);
    chk("t3_full_ready", in_ready, 0);
    in_valid = 1'b1;
    in_a = 9;
    in_b = 9;
    repeat (3) tick();
    in_valid = 1'b0;
    wait_valid();
    repeat (5) tick();
    chk("t3_stall_valid", out_valid, 1);
    chk("t3_stall_count", fifo_count, 4);
    chk("t3_stall_product", out_product, 100);
    out_ready = 1'b1;
    wait_q(5, "t3_results");
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("t3_product%0d", i), q_p[i], e3[i]);
      chk($sformatf("t3_b%0d", i), q_b[i], b3[i]);
    end
    repeat (30) tick();
    chk("t3_refused", q_p.size(), 5);
    chk("t3_empty", fifo_count, 0);

    clear_q();
    out_ready = 1'b0;
    push(2, 3);
    push(4, 5);
    push(6, 7);
    wait_valid();
    chk("t4_before", fifo_count, 2);
    out_ready = 1'b1;
    push(8, 9);
    chk("t4_after", fifo_count, 2);
    wait_q(4, "t4_results");
    for (int i = 0; i < 4; i++) chk($sformatf("t4_product%0d", i), q_p[i], e4[i]);
    repeat (3) tick();

    clear_q();
    hang = 1'b1;
    push(5, 6);
    t0 = cyc;
    push(2, 2);
    wait_valid();
    chk("t5_latency", cyc - t0, N + 4);
    chk("t5_proto_err", proto_err, 1);
    chk("t5_product", out_product, 0);
    chk("t5_a", out_a, 5);
    for (int i = 0; i < 6; i++) begin
      tick();
      chk($sformatf("t5_no_issue%0d", i), mul_start, 0);
    end
    chk("t5_queued", fifo_count, 1);
    hang = 1'b0;
    wait_q(2, "t5_results");
    chk("t5_next_product", q_p[1], 4);
    chk("t5_sticky", proto_err, 1);
    repeat (3) tick();

    clear_q();
    for (int i = 1; i <= 4; i++) push(N'(i), N'(i));
    chk("t6_queued", fifo_count, 3);
    reset = 1'b1;
    tick();
    chk("t6_count", fifo_count, 0);
    chk("t6_out_valid", out_valid, 0);
    chk("t6_mul_start", mul_start, 0);
    chk("t6_proto_err", proto_err, 0);
    reset = 1'b0;
    tick();
    clear_q();
    push(7, 9);
    wait_q(1, "t6_results");
    chk("t6_product", q_p[0], 63);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mult_dispatch.md
# mult_dispatch

Upstream feeder for the N-bit `SequentialMultiplier`. It accepts operand pairs over a valid/ready stream and buffers them in a DEPTH-entry FIFO. It issues one multiply at a time using the multiplier's start/ready protocol, then captures the product. Each result is presented downstream with its operands on a second valid/ready stream, and multiplier protocol violations are reported on a sticky error flag.

## Interface
- `N`, 8: operand width; the product is 2N bits.
- `DEPTH`, 4: FIFO entries; must be a power of two, at least 2.
- `clock`  in  1  Single clock; all state changes on posedge.
- `reset`  in  1  Synchronous, active-high reset, sampled on posedge clock.
- `in_valid`  in  1  Upstream operand pair valid.
- `in_ready`  out  1  FIFO can accept; equals `count != DEPTH`.
- `in_a`, `in_b`  in  N each  Multiplicand and multiplier.
- `mul_start`  out  1  Start pulse to the multiplier.
- `mul_multiplicand`, `mul_multiplier`  out  N each  Operands to the multiplier, held stable from the START cycle until the multiplier returns ready.
- `mul_ready`  in  1  Multiplier idle / result valid.
- `mul_product`  in  2N  Multiplier result.
- `out_valid`  out  1  Result valid.
- `out_ready`  in  1  Downstream accepts the result.
- `out_a`, `out_b`  out  N each  Operands belonging to `out_product`.
- `out_product`  out  2N  Captured product.
- `fifo_count`  out  $clog2(DEPTH)+1  Current FIFO occupancy.
- `proto_err`  out  1  Sticky multiplier protocol error.

## Operation
- FIFO
  - Push occurs when `in_valid && in_ready`.
  - Pop occurs on the START transition.
  - A simultaneous push and pop when full is not allowed, because `in_ready` is 0.
  - A simultaneous push and pop otherwise leaves the count unchanged.
  - Pointers wrap modulo DEPTH.
- FSM states: IDLE, START, WAIT, DONE.
  - IDLE: if `count != 0 && mul_ready`, pop the head into the operand registers and go to START.
  - START: assert `mul_start` for exactly this one cycle, then go to WAIT with the wait counter cleared.
  - WAIT: `mul_start` is 0.
    - If `mul_ready` is 1 in the first WAIT cycle, the multiplier failed to drop ready: set `proto_err`, treat it as completion, and go to DONE.
    - Otherwise, on the first cycle where `mul_ready` is 1, capture `mul_product` and the operands into the output registers and go to DONE.
    - If the wait counter reaches N+2 without `mul_ready`: set `proto_err`, capture `out_product = 0`, and go to DONE.
  - DONE: assert `out_valid`. When `out_ready` is 1:
    - If `count != 0 && mul_ready`, pop and go directly to START (back-to-back issue).
    - Otherwise go to IDLE.
- Outputs are registered, not combinational from the inputs, except `in_ready`, which is derived from the registered count.
- `out_*` are stable while `out_valid && !out_ready`.
- Products are passed through unmodified; the block does not compute or check them.
- `proto_err` is cleared only by reset.

## Timing
- Reset values: state IDLE, FIFO empty, `fifo_count` 0, `in_ready` 1, `mul_start` 0, operand and output registers 0, `out_valid` 0, `proto_err` 0.
- Reset mid-operation:
  - Within one cycle, `mul_start` is 0, the FIFO is flushed and any result is dropped.
  - The multiplier is expected to be reset alongside the block.
- Latency, with an empty FIFO, an idle multiplier and `out_ready` held high:
  - Push at edge t.
  - IDLE sees `count = 1` after t; the pop at edge t+1 enters START.
  - `mul_start` is high for cycle t+1..t+2.
  - WAIT begins at edge t+2; the multiplier completes N cycles later.
  - `out_valid` rises one edge after `mul_ready` is sampled high.
  - Total: N+3 cycles from push to `out_valid`.
- Throughput: one result per N+3 cycles with back-to-back issue from DONE. The issue skips IDLE only when `out_ready` is high in the DONE cycle.
- Output backpressure: while DONE is stalled, no new multiply is issued. The FIFO keeps filling until it is full, at which point `in_ready` drops to 0.

## Test plan
- Reset, then push the pair (3, 5) with `out_ready` = 1 -> `out_product` = 15, `out_a` = 3, `out_b` = 5; `out_valid` rises exactly N+3 cycles after the push; `proto_err` = 0.
- Push 4 pairs back-to-back: (255, 255), (0, 200), (1, 1), (128, 2), with `out_ready` = 1 -> results 65025, 0, 1, 256 in order; `in_ready` stays 1 throughout.
- Hold `out_ready` = 0 and push 6 pairs -> DONE stalls; `fifo_count` reaches 4; `in_ready` = 0 after the fifth accepted push; pairs 2–5 stay queued and pair 6 is refused. Release `out_ready` -> all 5 accepted results emerge in order with correct products.
- Simultaneous push and pop at `fifo_count` = 2 -> count stays 2; the pointer wrap after 5+ operations preserves ordering.
- Stub multiplier that never raises `mul_ready` after start -> `proto_err` = 1 after N+2 WAIT cycles; `out_valid` with `out_product` = 0; the next pair is not issued until `mul_ready` returns.
- Assert `reset` in the middle of WAIT with 3 entries queued -> next cycle: `fifo_count` 0, `out_valid` 0, `mul_start` 0, `proto_err` 0; a fresh pair (7, 9) afterwards yields 63.
